// File: rtl/fisqrt_sched_pkg.sv
// ---------------------------------------------------------------------------
// fisqrt_sched_pkg : shared types and constants for the fastInvSqrt scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fisqrt_sched_pkg;

  localparam int ID_W           = 3;
  localparam int FLAG_TIMEOUT   = 2;
  localparam int OFUF_OVERFLOW  = 1;
  localparam int OFUF_UNDERFLOW = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Round-robin pointer advance: the requester after the one just granted.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id, input int nreq);
    if (int'(id) >= nreq - 1) return '0;
    return id + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fisqrt_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin one-hot grant starting at i_ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_grant_id
);

  logic            w_hi_found;
  logic            w_lo_found;
  logic [ID_W-1:0] w_hi_id;
  logic [ID_W-1:0] w_lo_id;

  // Prefer the lowest requester at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_id    = '0;
    w_lo_id    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (i_req[j] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_id    = ID_W'(j);
      end
      if (i_req[j] && (ID_W'(j) >= i_ptr) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_id    = ID_W'(j);
      end
    end
  end

  always_comb begin
    o_grant_id = w_hi_found ? w_hi_id : w_lo_id;
    o_grant    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_lo_found && (ID_W'(j) == o_grant_id)) o_grant[j] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fisqrt_scheduler.sv
// ---------------------------------------------------------------------------
// fisqrt_scheduler : shares one fastInvSqrt unit among NREQ round-robin requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fisqrt_scheduler
  import fisqrt_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_result,
  output logic [2:0]           rsp_flags,
  output logic [15:0]          unit_x,
  output logic                 unit_start,
  input  logic                 unit_done,
  input  logic [15:0]          unit_result,
  input  logic [1:0]           unit_ofuf
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic [15:0]     r_operand;
  logic [15:0]     r_result;
  logic [2:0]      r_flags;
  logic [CNT_W-1:0] r_cnt;

  logic [NREQ-1:0] w_grant;
  logic [ID_W-1:0] w_grant_id;
  logic [15:0]     w_sel_x;
  logic            w_accept;
  logic            w_cnt_last;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  always_comb begin
    w_sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_sel_x = req_x[16*i +: 16];
    end
  end

  assign w_cnt_last = (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    unit_start  = reset;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_grant;
        w_accept  = |w_grant;
        if (w_accept) w_state_nxt = ST_LOAD;
      end
      ST_LOAD:  w_state_nxt = ST_START;
      ST_START: begin
        unit_start  = 1'b1;
        w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (unit_done || w_cnt_last) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Reset wins over the state-derived handshakes while it is held.
    if (reset) begin
      req_ready = '0;
      rsp_valid = 1'b0;
      w_accept  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_operand <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_id      <= w_grant_id;
        r_operand <= w_sel_x;
        r_ptr     <= next_ptr(w_grant_id, NREQ);
      end
      case (r_state)
        ST_START: r_cnt <= '0;
        ST_BUSY: begin
          if (unit_done) begin
            r_result <= unit_result;
            r_flags  <= {1'b0, unit_ofuf[OFUF_OVERFLOW], unit_ofuf[OFUF_UNDERFLOW]};
          end else if (w_cnt_last) begin
            r_result              <= '0;
            r_flags               <= '0;
            r_flags[FLAG_TIMEOUT] <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign unit_x     = r_operand;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_fisqrt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fisqrt_scheduler : directed self-checking bench with a stub fastInvSqrt unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fisqrt_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 20;
  localparam int LAT     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_x = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_id;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [15:0] unit_x;
  logic        unit_start;
  logic        unit_done = 1'b0;
  logic [15:0] unit_result = '0;
  logic [1:0]  unit_ofuf = '0;
  logic        stub_hang = 1'b0;
  int          ucnt = 0;

  int checks = 0;
  int failures = 0;

  fisqrt_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .unit_x(unit_x), .unit_start(unit_start), .unit_done(unit_done),
    .unit_result(unit_result), .unit_ofuf(unit_ofuf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f_res(input logic [15:0] x);
    case (x)
      16'h50BB: return 16'h3133;
      16'h4DE1: return 16'h3298;
      default:  return x ^ 16'hA5A5;
    endcase
  endfunction

  function automatic logic [1:0] f_ofuf(input logic [15:0] x);
    if (x == 16'h50BB || x == 16'h4DE1) return 2'b00;
    return x[1:0];
  endfunction

  // Stub unit: cleared while unit_start is high, raises done LAT cycles after release.
  always @(posedge clk) begin
    if (unit_start) begin
      ucnt      <= 0;
      unit_done <= 1'b0;
    end else if (!stub_hang && !unit_done) begin
      if (ucnt == LAT - 1) begin
        unit_done   <= 1'b1;
        unit_result <= f_res(unit_x);
        unit_ofuf   <= f_ofuf(unit_x);
      end else begin
        ucnt <= ucnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'b1111;
    step(); step();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (unit_start !== 1'b1) begin failures++; $display("FAIL reset_unit_start got=%b exp=1", unit_start); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 3'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_result !== 16'h0000) begin failures++; $display("FAIL reset_rsp_result got=%h exp=0000", rsp_result); end
    checks++; if (rsp_flags !== 3'b000) begin failures++; $display("FAIL reset_rsp_flags got=%b exp=000", rsp_flags); end
    checks++; if (unit_x !== 16'h0000) begin failures++; $display("FAIL reset_unit_x got=%h exp=0000", unit_x); end
    reset = 1'b0; req_valid = '0;
    step();
    checks++; if (unit_start !== 1'b0) begin failures++; $display("FAIL idle_unit_start got=%b exp=0", unit_start); end
  endtask

  task automatic test_single();
    int n;
    int nstart;
    req_x[15:0] = 16'h50BB; req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_load_ready got=%b exp=0000", req_ready); end
    checks++; if (unit_x !== 16'h50BB) begin failures++; $display("FAIL single_unit_x got=%h exp=50bb", unit_x); end
    checks++; if (unit_start !== 1'b0) begin failures++; $display("FAIL single_load_start got=%b exp=0", unit_start); end
    n = 0; nstart = 0;
    while (!rsp_valid && n < 200) begin
      if (unit_start) nstart++;
      step();
      n++;
    end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_timeout got=%b exp=1", rsp_valid); end
    checks++; if (n != LAT + 3) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", n, LAT + 3); end
    checks++; if (nstart != 1) begin failures++; $display("FAIL single_start_cycles got=%0d exp=1", nstart); end
    checks++; if (rsp_id !== 3'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_result !== 16'h3133) begin failures++; $display("FAIL single_result got=%h exp=3133", rsp_result); end
    checks++; if (rsp_flags !== 3'b000) begin failures++; $display("FAIL single_flags got=%b exp=000", rsp_flags); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_two();
    int n;
    do_reset();
    req_x[15:0] = 16'h50BB; req_x[31:16] = 16'h4DE1; req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL two_first_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0010;
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL two_rsp0_timeout got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 3'd0) begin failures++; $display("FAIL two_id0 got=%0d exp=0", rsp_id); end
    checks++; if (rsp_result !== 16'h3133) begin failures++; $display("FAIL two_result0 got=%h exp=3133", rsp_result); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL two_b2b_grant got=%b exp=0010", req_ready); end
    step();
    req_valid = '0;
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL two_rsp1_timeout got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 3'd1) begin failures++; $display("FAIL two_id1 got=%0d exp=1", rsp_id); end
    checks++; if (rsp_result !== 16'h3298) begin failures++; $display("FAIL two_result1 got=%h exp=3298", rsp_result); end
    checks++; if (rsp_flags !== 3'b000) begin failures++; $display("FAIL two_flags1 got=%b exp=000", rsp_flags); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL two_wrap_grant got=%b exp=0001", req_ready); end
    req_valid = '0;
    #1;
  endtask

  task automatic test_rr_all();
    int n;
    logic [3:0]  exp_g;
    logic [15:0] xs [4];
    xs[0] = 16'h1001; xs[1] = 16'h2002; xs[2] = 16'h3C03; xs[3] = 16'h4400;
    do_reset();
    for (int i = 0; i < 4; i++) req_x[16*i +: 16] = xs[i];
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL rr_grant op%0d got=%b exp=%b", k, req_ready, exp_g); end
      step();
      wait_rsp(n);
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rr_rsp_timeout op%0d got=%b exp=1", k, rsp_valid); end
      checks++; if (rsp_id !== 3'(k % 4)) begin failures++; $display("FAIL rr_id op%0d got=%0d exp=%0d", k, rsp_id, k % 4); end
      checks++; if (rsp_result !== f_res(xs[k % 4])) begin failures++; $display("FAIL rr_result op%0d got=%h exp=%h", k, rsp_result, f_res(xs[k % 4])); end
      checks++; if (rsp_flags !== {1'b0, f_ofuf(xs[k % 4])}) begin failures++; $display("FAIL rr_flags op%0d got=%b exp=%b", k, rsp_flags, {1'b0, f_ofuf(xs[k % 4])}); end
      step();
    end
    req_valid = '0; rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    stub_hang = 1'b1;
    req_x[15:0] = 16'h50BB; req_valid = 4'b0001;
    #1;
    step();
    req_valid = '0;
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL tmo_rsp_timeout got=%b exp=1", rsp_valid); end
    checks++; if (n != TIMEOUT + 2) begin failures++; $display("FAIL tmo_cycles got=%0d exp=%0d", n, TIMEOUT + 2); end
    checks++; if (rsp_flags !== 3'b100) begin failures++; $display("FAIL tmo_flags got=%b exp=100", rsp_flags); end
    checks++; if (rsp_result !== 16'h0000) begin failures++; $display("FAIL tmo_result got=%h exp=0000", rsp_result); end
    checks++; if (rsp_id !== 3'd0) begin failures++; $display("FAIL tmo_id got=%0d exp=0", rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    stub_hang = 1'b0;
    #1;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    req_x[31:16] = 16'h50BB; req_x[47:32] = 16'h4DE1; req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant1 got=%b exp=0010", req_ready); end
    step();
    req_valid = 4'b0101;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc%0d got=%b exp=1", i, rsp_valid); end
      checks++; if (rsp_id !== 3'd1) begin failures++; $display("FAIL bp_hold_id cyc%0d got=%0d exp=1", i, rsp_id); end
      checks++; if (rsp_result !== 16'h3133) begin failures++; $display("FAIL bp_hold_result cyc%0d got=%h exp=3133", i, rsp_result); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_no_grant cyc%0d got=%b exp=0000", i, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_resume_grant got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    wait_rsp(n);
    checks++; if (rsp_id !== 3'd2) begin failures++; $display("FAIL bp_id2 got=%0d exp=2", rsp_id); end
    checks++; if (rsp_result !== 16'h3298) begin failures++; $display("FAIL bp_result2 got=%h exp=3298", rsp_result); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    req_x[31:16] = 16'h2002; req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rm_grant got=%b exp=0010", req_ready); end
    step();
    req_valid = '0;
    step(); step(); step();
    reset = 1'b1; req_valid = 4'b0110;
    #1;
    checks++; if (unit_start !== 1'b1) begin failures++; $display("FAIL rm_unit_start got=%b exp=1", unit_start); end
    step();
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rm_ptr_zero got=%b exp=0010", req_ready); end
    checks++; if (unit_x !== 16'h0000) begin failures++; $display("FAIL rm_unit_x got=%h exp=0000", unit_x); end
    req_valid = '0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rm_no_response got=%0d exp=0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_two();
    test_rr_all();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
